// File: rtl/controller_reduce_pkg.sv
// rtl/controller_reduce_pkg.sv - shared codes and state encoding for the reduction sequencer
package controller_reduce_pkg;

    localparam logic [1:0] RM_PREC  = 2'd0;
    localparam logic [1:0] RM_ALL   = 2'd1;
    localparam logic [1:0] RM_PAREN = 2'd2;

    localparam logic [2:0] RE_NONE      = 3'd0;
    localparam logic [2:0] RE_UNDERFLOW = 3'd1;
    localparam logic [2:0] RE_PAREN     = 3'd2;
    localparam logic [2:0] RE_OPFULL    = 3'd3;
    localparam logic [2:0] RE_ALU       = 3'd4;

    localparam int         CO_W  = 4;
    localparam logic [3:0] CO_AD = 4'h0;
    localparam logic [3:0] CO_SB = 4'h1;
    localparam logic [3:0] CO_ML = 4'h2;
    localparam logic [3:0] CO_LP = 4'hE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_POP_B,
        S_POP_A,
        S_EXEC,
        S_WAIT,
        S_PUSH,
        S_PUSH_OP,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/controller_reduce.sv
// rtl/controller_reduce.sv - operator-stack reduction sequencer driving stacks, ALU and precedence ROM
module controller_reduce
    import controller_reduce_pkg::*;
#(
    parameter int DW = 8,
    parameter int OW = CO_W
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [OW-1:0] in_op,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [OW-1:0] pr_A,
    output logic [OW-1:0] pr_B,
    input  logic          pr_res,
    input  logic [OW-1:0] op_data,
    input  logic          op_empty,
    input  logic          op_full,
    output logic          op_pop,
    output logic          op_push,
    output logic [OW-1:0] op_wdata,
    input  logic [DW-1:0] dt_data,
    input  logic          dt_empty,
    output logic          dt_pop,
    output logic          dt_push,
    output logic [DW-1:0] dt_wdata,
    output logic          al_start,
    output logic [OW-1:0] al_op,
    output logic [DW-1:0] al_A,
    output logic [DW-1:0] al_B,
    input  logic          al_done,
    input  logic          al_err,
    input  logic [DW-1:0] al_C
);

    localparam logic [OW-1:0] OP_AD = OW'(CO_AD);
    localparam logic [OW-1:0] OP_LP = OW'(CO_LP);

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [OW-1:0] in_op_q, in_op_d;
    logic [OW-1:0] op_q, op_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] c_q, c_d;
    logic [2:0]    err_code_q, err_code_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            mode_q     <= RM_PREC;
            in_op_q    <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            err_code_q <= RE_NONE;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            in_op_q    <= in_op_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        in_op_d    = in_op_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        err_code_d = err_code_q;
        done       = 1'b0;
        err        = 1'b0;
        pr_A       = OP_AD;
        pr_B       = OP_AD;
        op_pop     = 1'b0;
        op_push    = 1'b0;
        dt_pop     = 1'b0;
        dt_push    = 1'b0;
        al_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    in_op_d    = in_op;
                    err_code_d = RE_NONE;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                pr_A = op_data;
                pr_B = in_op_q;
                if (op_empty) begin
                    if (mode_q == RM_PREC) begin
                        state_d = S_PUSH_OP;
                    end else if (mode_q == RM_PAREN) begin
                        err_code_d = RE_PAREN;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (op_data == OP_LP) begin
                    // '(' is a barrier: only a ')' reduction may consume it
                    if (mode_q == RM_PREC) begin
                        state_d = S_PUSH_OP;
                    end else if (mode_q == RM_PAREN) begin
                        op_pop  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_code_d = RE_PAREN;
                        state_d    = S_ERR;
                    end
                end else if (mode_q == RM_PREC && !pr_res) begin
                    state_d = S_PUSH_OP;
                end else begin
                    op_d    = op_data;
                    op_pop  = 1'b1;
                    state_d = S_POP_B;
                end
            end
            S_POP_B: begin
                if (dt_empty) begin
                    err_code_d = RE_UNDERFLOW;
                    state_d    = S_ERR;
                end else begin
                    b_d     = dt_data;
                    dt_pop  = 1'b1;
                    state_d = S_POP_A;
                end
            end
            S_POP_A: begin
                if (dt_empty) begin
                    err_code_d = RE_UNDERFLOW;
                    state_d    = S_ERR;
                end else begin
                    a_d     = dt_data;
                    dt_pop  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                al_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (al_done) begin
                    if (al_err) begin
                        err_code_d = RE_ALU;
                        state_d    = S_ERR;
                    end else begin
                        c_d     = al_C;
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                dt_push = 1'b1;
                state_d = S_CHECK;
            end
            S_PUSH_OP: begin
                if (op_full) begin
                    err_code_d = RE_OPFULL;
                    state_d    = S_ERR;
                end else begin
                    op_push = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The reset cycle must not leak a strobe decoded from the stale state
        if (!Reset) begin
            done     = 1'b0;
            err      = 1'b0;
            pr_A     = OP_AD;
            pr_B     = OP_AD;
            op_pop   = 1'b0;
            op_push  = 1'b0;
            dt_pop   = 1'b0;
            dt_push  = 1'b0;
            al_start = 1'b0;
        end
    end

    assign busy     = Reset && (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign err_code = err_code_q;
    assign op_wdata = in_op_q;
    assign dt_wdata = c_q;
    assign al_op    = op_q;
    assign al_A     = a_q;
    assign al_B     = b_q;

endmodule

// File: tb/tb_controller_reduce.sv
// tb/tb_controller_reduce.sv - directed bench with stack, ALU and precedence ROM models
module tb_controller_reduce;
    import controller_reduce_pkg::*;

    localparam int DW = 8;
    localparam int OW = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [OW-1:0] in_op = '0;
    logic          busy, done, err;
    logic [2:0]    err_code;
    logic [OW-1:0] pr_A, pr_B;
    logic          pr_res;
    logic [OW-1:0] op_data;
    logic          op_empty, op_full, op_pop, op_push;
    logic [OW-1:0] op_wdata;
    logic [DW-1:0] dt_data;
    logic          dt_empty, dt_pop, dt_push;
    logic [DW-1:0] dt_wdata;
    logic          al_start;
    logic [OW-1:0] al_op;
    logic [DW-1:0] al_A, al_B;
    logic          al_done = 1'b0, al_err = 1'b0;
    logic [DW-1:0] al_C = '0;

    always #5 Clock = ~Clock;

    controller_reduce #(.DW(DW), .OW(OW)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .mode(mode), .in_op(in_op),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .pr_A(pr_A), .pr_B(pr_B), .pr_res(pr_res),
        .op_data(op_data), .op_empty(op_empty), .op_full(op_full),
        .op_pop(op_pop), .op_push(op_push), .op_wdata(op_wdata),
        .dt_data(dt_data), .dt_empty(dt_empty), .dt_pop(dt_pop),
        .dt_push(dt_push), .dt_wdata(dt_wdata),
        .al_start(al_start), .al_op(al_op), .al_A(al_A), .al_B(al_B),
        .al_done(al_done), .al_err(al_err), .al_C(al_C)
    );

    // ---------------- environment models ----------------
    logic [OW-1:0] op_stk [0:7];
    logic [DW-1:0] dt_stk [0:7];
    int            op_cnt = 0, dt_cnt = 0, dt_pop_cnt = 0;
    logic [OW-1:0] pre_op [0:1];
    logic [DW-1:0] pre_dt [0:2];
    int            pre_op_n = 0, pre_dt_n = 0, op_cap = 8;
    logic          load_req = 1'b0;

    assign op_data  = (op_cnt > 0) ? op_stk[op_cnt-1] : '0;
    assign op_empty = (op_cnt == 0);
    assign op_full  = (op_cnt >= op_cap);
    assign dt_data  = (dt_cnt > 0) ? dt_stk[dt_cnt-1] : '0;
    assign dt_empty = (dt_cnt == 0);

    always @(posedge Clock) begin
        if (load_req) begin
            op_cnt     <= pre_op_n;
            dt_cnt     <= pre_dt_n;
            dt_pop_cnt <= 0;
            for (int i = 0; i < 2; i++) op_stk[i] <= pre_op[i];
            for (int i = 0; i < 3; i++) dt_stk[i] <= pre_dt[i];
        end else begin
            if (op_pop && op_cnt > 0) op_cnt <= op_cnt - 1;
            if (op_push) begin
                op_stk[op_cnt] <= op_wdata;
                op_cnt         <= op_cnt + 1;
            end
            if (dt_pop && dt_cnt > 0) begin
                dt_cnt     <= dt_cnt - 1;
                dt_pop_cnt <= dt_pop_cnt + 1;
            end
            if (dt_push) begin
                dt_stk[dt_cnt] <= dt_wdata;
                dt_cnt         <= dt_cnt + 1;
            end
        end
    end

    function automatic int prec(input logic [OW-1:0] op);
        if (op == CO_ML) return 2;
        if (op == CO_AD || op == CO_SB) return 1;
        return 0;
    endfunction
    assign pr_res = (prec(pr_A) >= prec(pr_B));

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        if (op == CO_ML) return a * b;
        if (op == CO_SB) return a - b;
        return a + b;
    endfunction

    int            alu_lat = 1, alu_cnt = 0, alu_done_cnt = 0;
    logic          alu_err_force = 1'b0;
    logic [DW-1:0] alu_res = '0;
    logic [OW-1:0] cap_op = '0;
    logic [DW-1:0] cap_a = '0, cap_b = '0;

    always @(posedge Clock) begin
        al_done <= 1'b0;
        al_err  <= 1'b0;
        if (al_start) begin
            cap_op <= al_op;
            cap_a  <= al_A;
            cap_b  <= al_B;
            if (alu_lat <= 1) begin
                al_done      <= 1'b1;
                al_err       <= alu_err_force;
                al_C         <= alu_f(al_op, al_A, al_B);
                alu_done_cnt <= alu_done_cnt + 1;
            end else begin
                alu_cnt <= alu_lat - 1;
                alu_res <= alu_f(al_op, al_A, al_B);
            end
        end else if (alu_cnt > 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) begin
                al_done      <= 1'b1;
                al_err       <= alu_err_force;
                al_C         <= alu_res;
                alu_done_cnt <= alu_done_cnt + 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0, fails = 0;
    int cyc;
    logic end_done, end_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int on, input logic [OW-1:0] o0, o1,
                        input int dn, input logic [DW-1:0] d0, d1, d2);
        pre_op_n = on; pre_op[0] = o0; pre_op[1] = o1;
        pre_dt_n = dn; pre_dt[0] = d0; pre_dt[1] = d1; pre_dt[2] = d2;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] m, input logic [OW-1:0] op);
        mode  = m;
        in_op = op;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_code_clr"}, 32'(err_code), 32'd0);
        while (!done && !err && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 200), 32'd1);
        end_done = done;
        end_err  = err;
        tick();
    endtask

    logic seen_bad;
    int   dn_before;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_prA", 32'(pr_A), 32'(CO_AD));
        chk("rst_prB", 32'(pr_B), 32'(CO_AD));
        chk("rst_strobes", 32'({op_pop, op_push, dt_pop, dt_push, al_start}), 32'd0);
        chk("rst_regs", 32'({al_A, al_B, dt_wdata}), 32'd0);
        Reset = 1'b1;
        tick();

        // PREC, no reduction
        load(1, CO_AD, 0, 2, 8'd2, 8'd3, 0);
        run("t1", RM_PREC, CO_ML);
        chk("t1_done", 32'({end_done, end_err}), 32'b10);
        chk("t1_cyc", 32'(cyc), 32'd3);
        chk("t1_opcnt", 32'(op_cnt), 32'd2);
        chk("t1_optop", 32'(op_data), 32'(CO_ML));
        chk("t1_dtcnt", 32'(dt_cnt), 32'd2);
        chk("t1_idle", 32'(busy), 32'd0);

        // PREC with one reduction
        load(1, CO_ML, 0, 2, 8'd2, 8'd3, 0);
        run("t2", RM_PREC, CO_AD);
        chk("t2_done", 32'({end_done, end_err}), 32'b10);
        chk("t2_cyc", 32'(cyc), 32'd9);
        chk("t2_alop", 32'(cap_op), 32'(CO_ML));
        chk("t2_alA", 32'(cap_a), 32'd2);
        chk("t2_alB", 32'(cap_b), 32'd3);
        chk("t2_dt", 32'(dt_cnt), 32'd1);
        chk("t2_dttop", 32'(dt_data), 32'd6);
        chk("t2_op", 32'(op_cnt), 32'd1);
        chk("t2_optop", 32'(op_data), 32'(CO_AD));

        // ALL: two reductions with a slower ALU
        alu_lat = 3;
        load(2, CO_AD, CO_ML, 3, 8'd1, 8'd2, 8'd3);
        run("t3", RM_ALL, CO_AD);
        chk("t3_done", 32'({end_done, end_err}), 32'b10);
        chk("t3_cyc", 32'(cyc), 32'd18);
        chk("t3_dt", 32'(dt_cnt), 32'd1);
        chk("t3_dttop", 32'(dt_data), 32'd7);
        chk("t3_op", 32'(op_cnt), 32'd0);
        alu_lat = 1;

        // PAREN reduces to '(' and pops it; repeat start finds no '('
        load(2, CO_LP, CO_AD, 2, 8'd1, 8'd2, 0);
        run("t4", RM_PAREN, CO_AD);
        chk("t4_done", 32'({end_done, end_err}), 32'b10);
        chk("t4_cyc", 32'(cyc), 32'd8);
        chk("t4_dttop", 32'(dt_data), 32'd3);
        chk("t4_dt", 32'(dt_cnt), 32'd1);
        chk("t4_op", 32'(op_cnt), 32'd0);
        run("t4b", RM_PAREN, CO_AD);
        chk("t4b_err", 32'({end_done, end_err}), 32'b01);
        chk("t4b_code", 32'(err_code), 32'd2);

        // ALL over '(' is a paren error
        load(1, CO_LP, 0, 1, 8'd4, 0, 0);
        run("t4c", RM_ALL, CO_AD);
        chk("t4c_err", 32'({end_done, end_err}), 32'b01);
        chk("t4c_code", 32'(err_code), 32'd2);

        // data underflow
        load(1, CO_AD, 0, 1, 8'd5, 0, 0);
        run("t5", RM_ALL, CO_AD);
        chk("t5_err", 32'({end_done, end_err}), 32'b01);
        chk("t5_cyc", 32'(cyc), 32'd4);
        chk("t5_code", 32'(err_code), 32'd1);
        chk("t5_pops", 32'(dt_pop_cnt), 32'd1);
        chk("t5_op", 32'(op_cnt), 32'd0);

        // operator stack full on push
        op_cap = 1;
        load(1, CO_AD, 0, 2, 8'd2, 8'd3, 0);
        run("t6", RM_PREC, CO_ML);
        chk("t6_err", 32'({end_done, end_err}), 32'b01);
        chk("t6_code", 32'(err_code), 32'd3);
        chk("t6_op", 32'(op_cnt), 32'd1);
        op_cap = 8;

        // ALU error
        alu_err_force = 1'b1;
        load(1, CO_AD, 0, 2, 8'd1, 8'd2, 0);
        run("t7", RM_ALL, CO_AD);
        chk("t7_err", 32'({end_done, end_err}), 32'b01);
        chk("t7_code", 32'(err_code), 32'd4);
        chk("t7_dt", 32'(dt_cnt), 32'd0);
        alu_err_force = 1'b0;

        // reset while waiting on a slow ALU
        alu_lat = 6;
        load(1, CO_AD, 0, 2, 8'd2, 8'd3, 0);
        dn_before = alu_done_cnt;
        mode  = RM_ALL;
        in_op = CO_AD;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t8_inwait", 32'({busy, al_start}), 32'b10);
        Reset = 1'b0;
        #1;
        chk("t8_rcyc_busy", 32'(busy), 32'd0);
        chk("t8_rcyc_strb", 32'({op_pop, op_push, dt_pop, dt_push, al_start, done, err}), 32'd0);
        tick();
        Reset = 1'b1;
        #1;
        chk("t8_after_busy", 32'(busy), 32'd0);
        chk("t8_after_regs", 32'({al_op, al_A, al_B, dt_wdata, err_code}), 32'd0);
        chk("t8_after_pr", 32'({pr_A, pr_B}), 32'({CO_AD, CO_AD}));
        seen_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || done || err || dt_push || op_push || al_start) seen_bad = 1'b1;
        end
        chk("t8_late_done_seen", 32'(alu_done_cnt - dn_before), 32'd1);
        chk("t8_ignored", 32'(seen_bad), 32'd0);
        chk("t8_dt", 32'(dt_cnt), 32'd0);
        alu_lat = 1;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/controller_reduce.md
# controller_reduce

Operator-stack reduction sequencer for the calculator controller. On a request it drives the precedence ROM and pops operators and operand pairs from the operator and data stacks. It runs each pair through the ALU, pushes results back, and finally pushes the incoming operator or discards a matching '('. It sits between the command decoder and the stack memories, the ALU and the precedence ROM, and owns their control strobes while busy.

## Interface
- DW, `CD_N: data-stack word width
- OW, `CO_N: operator code width
- Clock  in  1  rising-edge clock
- Reset  in  1  reset Reset, synchronous, active-low
- start  in  1  request pulse; ignored while busy
- mode  in  2  `RM_PREC reduce-then-push, `RM_ALL reduce to empty ('='), `RM_PAREN reduce to '(' (')')
- in_op  in  OW  incoming operator; used only by `RM_PREC
- busy  out  1  high from the cycle after an accepted start until done/err
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse; replaces done
- err_code  out  3  `RE_UNDERFLOW=1, `RE_PAREN=2, `RE_OPFULL=3, `RE_ALU=4; held until next start
- pr_A, pr_B  out  OW  precedence ROM operands (top of stack, incoming)
- pr_res  in  1  1 = pr_A binds at least as tightly as pr_B (reduce)
- op_data  in  OW, op_empty  in  1, op_full  in  1  operator stack top and flags
- op_pop  out  1, op_push  out  1, op_wdata  out  OW  operator stack strobes
- dt_data  in  DW, dt_empty  in  1  data stack top and flag
- dt_pop  out  1, dt_push  out  1, dt_wdata  out  DW  data stack strobes
- al_start  out  1, al_op  out  OW, al_A  out  DW, al_B  out  DW  ALU request
- al_done  in  1, al_err  in  1, al_C  in  DW  ALU completion, error, result

## Operation
- States: IDLE, CHECK, POP_B, POP_A, EXEC, WAIT, PUSH, PUSH_OP, DONE, ERR.
- IDLE: on start, latch mode and in_op, then go to CHECK.
- CHECK, decided combinationally on pr_res, which is valid in the same cycle:
  - op_empty: PREC goes to PUSH_OP, ALL goes to DONE, PAREN goes to ERR(PAREN).
  - op_data==`CO_LP: PREC goes to PUSH_OP, ALL goes to ERR(PAREN), PAREN pulses op_pop and goes to DONE.
  - Otherwise, PREC with pr_res=0 goes to PUSH_OP. Any other case latches op_data into the operator register, pulses op_pop and goes to POP_B.
- POP_B: if dt_empty, go to ERR(UNDERFLOW). Otherwise latch dt_data as B, pulse dt_pop, go to POP_A.
- POP_A: same underflow check. Otherwise latch dt_data as A, pulse dt_pop, go to EXEC.
- EXEC: al_start high for exactly one cycle, with al_op, al_A and al_B stable from EXEC until WAIT exits; then go to WAIT.
- WAIT: hold until al_done. If al_err, go to ERR(ALU). Otherwise latch al_C and go to PUSH.
- PUSH: dt_push with dt_wdata set to the latched result, then go to CHECK.
- PUSH_OP: if op_full, go to ERR(OPFULL). Otherwise op_push with op_wdata=in_op, then go to DONE.
- DONE and ERR: pulse the matching output for one cycle, then go to IDLE.
- Stack strobes are mutually exclusive per stack and last one cycle. Pops take effect at the clock edge, and the stack top is valid the cycle after the edge.
- pr_A=op_data and pr_B=in_op in CHECK. pr_A and pr_B are `CO_AD in every other state.
- Errors leave the stacks partially consumed. Clearing the stacks is the decoder's job.

## Timing
- Reset values: state IDLE. busy, done, err and all strobes are 0. err_code is 0. pr_A and pr_B are `CO_AD. Data and operator registers are 0.
- Reset asserted in any state forces IDLE on the next edge, and no strobe fires in the reset cycle.
- start to busy: 1 cycle.
- One reduction takes 6 cycles plus ALU latency − 1 (CHECK through PUSH; the minimum al_done is 1 cycle after al_start).
- PREC with no reduction: start, CHECK, PUSH_OP, then done 3 cycles after start.
- al_done is not sampled in the EXEC cycle.

## Structure
- `RM_*, `RE_* and the state encodings go in CONT_INTERNAL.v.
- `CO_* operator codes, including `CO_LP and `CO_AD, stay in CPU_INTERNAL.v.
- Single module with no sub-module. The precedence ROM, the stacks and the ALU are external.

## Test plan
- Ops [ADD], dt [2,3]; start PREC with MUL and pr_res=0 → no pops, op_push MUL; ops [ADD,MUL], done at cycle 3.
- Ops [MUL], dt [2,3]; start PREC with ADD → al_op=MUL, A=2, B=3; push 6; ops [ADD], dt [6].
- Ops [ADD,MUL], dt [1,2,3]; start ALL → MUL gives 6, then ADD gives 7; dt [7], ops empty, done.
- Ops [LP,ADD], dt [1,2]; start PAREN → dt [3], LP popped, ops empty, done. A repeat start gives err with code 2.
- Ops [ADD], dt [5]; start ALL → one dt_pop, then err with err_code=1. Also cover op_full on PUSH_OP → err with code 3.
- Reset pulled low in WAIT → IDLE next cycle with all outputs at reset values; the late al_done is ignored.
